// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 ALU and its arbiter: funct3 encodings,
// default width and an id-width helper.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_SLL  = 3'b001;
   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU = 3'b011;
   localparam logic [2:0] FUNCT3_XOR  = 3'b100;
   localparam logic [2:0] FUNCT3_SR   = 3'b101;
   localparam logic [2:0] FUNCT3_OR   = 3'b110;
   localparam logic [2:0] FUNCT3_AND  = 3'b111;

   // ceil(log2(n)), never below 1 so a 1-bit id exists even for tiny n
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < n) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU; alt selects SUB for ADD and SRA for SRL.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       op,
   input  logic             alt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [4:0]              shamt;
   logic signed [WIDTH-1:0] sra;

   assign shamt = b[4:0];
   assign sra   = $signed(a) >>> shamt;

   always_comb begin
      y = '0;
      case (op)
         FUNCT3_ADD:  y = alt ? (a - b) : (a + b);
         FUNCT3_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         FUNCT3_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
         FUNCT3_AND:  y = a & b;
         FUNCT3_OR:   y = a | b;
         FUNCT3_XOR:  y = a ^ b;
         FUNCT3_SLL:  y = a << shamt;
         FUNCT3_SR:   y = alt ? sra : (a >> shamt);
         default:     y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters, with a
// single registered, tagged response slot that can refill while it drains.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int NREQ  = 2,
   parameter int IDW   = clog2_min1(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [3*NREQ-1:0]     req_op,
   input  logic [NREQ-1:0]       req_alt,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  busy
);

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   idx;
   logic [IDW-1:0]   ptr_nxt;
   logic             win_vld;
   logic             can_issue;
   logic             accept;
   logic [2:0]       op_w;
   logic             alt_w;
   logic [WIDTH-1:0] a_w;
   logic [WIDTH-1:0] b_w;
   logic [WIDTH-1:0] alu_y;

   assign can_issue = !rsp_valid || rsp_ready;
   assign accept    = win_vld && can_issue && !rst;
   assign busy      = rsp_valid;

   // Scan from the far end back toward ptr so the nearest requester is written last and wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (req_valid[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win] = 1'b1;
   end

   assign ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

   assign op_w  = req_op[3*win +: 3];
   assign alt_w = req_alt[win];
   assign a_w   = req_a[WIDTH*win +: WIDTH];
   assign b_w   = req_b[WIDTH*win +: WIDTH];

   alu #(.WIDTH(WIDTH)) u_alu (
      .op  (op_w),
      .alt (alt_w),
      .a   (a_w),
      .b   (b_w),
      .y   (alu_y)
   );

   // A same-cycle drain and accept simply overwrites the slot, so there is no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         ptr        <= '0;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= win;
         rsp_result <= alu_y;
         ptr        <= ptr_nxt;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a queue-free
// behavioural model of the arbitration rules and RV32 ALU arithmetic.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 32;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_op;
   logic [NREQ-1:0]   req_alt;
   logic [W*NREQ-1:0] req_a;
   logic [W*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [0:0]        rsp_id;
   logic [W-1:0]      rsp_result;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Model state
   bit          m_valid;
   int          m_id;
   logic [31:0] m_res;
   int          m_ptr;
   logic [NREQ-1:0] last_rdy;

   alu_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_alt    (req_alt),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
      int s;
      s = int'(b[4:0]);
      case (op)
         3'd0: return alt ? (a + ~b + 32'd1) : (a + b);
         3'd2: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd7: return a & b;
         3'd6: return a | b;
         3'd4: return a ^ b;
         3'd1: return a * (32'd1 << s);
         default: return (alt && a[31]) ? ~((~a) >> s) : (a >> s);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic alt,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[i]     = v;
      req_op[3*i +: 3] = op;
      req_alt[i]       = alt;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
   task automatic cycle();
      int w;
      logic [NREQ-1:0] exp_rdy;
      bit n_valid;
      int n_id, n_ptr;
      logic [31:0] n_res;
      @(negedge clk);
      w = -1;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      if (w >= 0 && (!m_valid || rsp_ready) && !rst) exp_rdy[w] = 1'b1;
      check("req_ready",  32'(req_ready),  32'(exp_rdy));
      check("rsp_valid",  32'(rsp_valid),  32'(m_valid));
      check("busy",       32'(busy),       32'(m_valid));
      check("rsp_id",     32'(rsp_id),     32'(m_id));
      check("rsp_result", rsp_result,      m_res);
      n_valid = m_valid; n_id = m_id; n_res = m_res; n_ptr = m_ptr;
      if (rst) begin
         n_valid = 0; n_id = 0; n_res = '0; n_ptr = 0;
      end else if (exp_rdy != '0) begin
         n_valid = 1; n_id = w; n_ptr = (w + 1) % NREQ;
         n_res = ref_alu(req_op[3*w +: 3], req_alt[w], req_a[W*w +: W], req_b[W*w +: W]);
      end else if (rsp_ready) begin
         n_valid = 0;
      end
      last_rdy = exp_rdy;
      @(posedge clk);
      #1;
      m_valid = n_valid; m_id = n_id; m_res = n_res; m_ptr = n_ptr;
   endtask

   initial begin
      logic [31:0] held;
      logic [2:0]  ops  [4];
      logic        alts [4];
      logic [31:0] as   [4];
      logic [31:0] bs   [4];
      logic [31:0] exps [4];

      rst = 1'b1; rsp_ready = 1'b0;
      req_valid = '0; req_op = '0; req_alt = '0; req_a = '0; req_b = '0;
      m_valid = 0; m_id = 0; m_res = '0; m_ptr = 0; last_rdy = '0;
      @(posedge clk); #1;

      // Reset then idle
      cycle(); cycle();
      rst = 1'b0;
      cycle();
      check("idle_result", rsp_result, 32'h0);

      // Single ADD then SUB from requester 0
      rsp_ready = 1'b1;
      set_req(0, 1, 3'b000, 0, 32'd5, 32'd7);
      cycle();
      req_valid = '0;
      check("add_valid", 32'(rsp_valid), 32'd1);
      check("add_id",    32'(rsp_id),    32'd0);
      check("add_res",   rsp_result,     32'd12);
      set_req(0, 1, 3'b000, 1, 32'd3, 32'd5);
      cycle();
      req_valid = '0;
      check("sub_res", rsp_result, 32'hFFFFFFFE);
      cycle();

      // Round-robin: ptr sits at 1 after requester 0's SUB, so grants go 1,0,1,0
      set_req(0, 1, 3'b000, 0, 32'd100, 32'd1);
      set_req(1, 1, 3'b000, 0, 32'd200, 32'd2);
      for (int n = 0; n < 4; n++) begin
         cycle();
         check("rr_valid", 32'(rsp_valid), 32'd1);
         check("rr_id",    32'(rsp_id),    (n % 2 == 0) ? 32'd1 : 32'd0);
      end

      // Backpressure with an XOR pending on requester 1
      req_valid[0] = 1'b0;
      set_req(1, 1, 3'b100, 0, 32'hFFFF0000, 32'h0F0F0F0F);
      rsp_ready = 1'b0;
      held = rsp_result;
      for (int n = 0; n < 3; n++) begin
         cycle();
         check("stall_ready", 32'(req_ready), 32'd0);
         check("stall_hold",  rsp_result,     held);
      end
      rsp_ready = 1'b1;
      cycle();
      req_valid = '0;
      check("xor_res", rsp_result, 32'hF0F00F0F);
      check("xor_id",  32'(rsp_id), 32'd1);

      // Op coverage via requester 1
      ops[0] = 3'b010; alts[0] = 0; as[0] = 32'hFFFFFFFF; bs[0] = 32'd1;  exps[0] = 32'd1;
      ops[1] = 3'b011; alts[1] = 0; as[1] = 32'hFFFFFFFF; bs[1] = 32'd1;  exps[1] = 32'd0;
      ops[2] = 3'b101; alts[2] = 1; as[2] = 32'h80000000; bs[2] = 32'd4;  exps[2] = 32'hF8000000;
      ops[3] = 3'b001; alts[3] = 0; as[3] = 32'h00000001; bs[3] = 32'd33; exps[3] = 32'd2;
      for (int n = 0; n < 4; n++) begin
         set_req(1, 1, ops[n], alts[n], as[n], bs[n]);
         cycle();
         check("op_res", rsp_result, exps[n]);
      end
      req_valid = '0;
      cycle();

      // Reset mid-stall, then requester 0 must win a tie
      set_req(1, 1, 3'b110, 0, 32'h00F0, 32'h0F00);
      cycle();
      req_valid = '0;
      rsp_ready = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b1;
      set_req(0, 1, 3'b111, 0, 32'hF0F0, 32'hFF00);
      set_req(1, 1, 3'b000, 0, 32'd1, 32'd1);
      cycle();
      req_valid = '0;
      check("rst_tie_id", 32'(rsp_id), 32'd0);
      cycle();

      // Randomized traffic, holding fields stable while valid and not yet accepted
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!(req_valid[i] && !last_rdy[i])) begin
               set_req(i, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), $urandom(),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom());
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
